alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit combinational ALU.
- Captures result, carryout and overflow together with the 3-bit command that produced them, using a valid/ready handshake.
- Buffers up to 2 results in a skid FIFO so a stalled consumer never corrupts an in-flight ALU result.
- Qualifies flags per command, recomputes zero locally, and keeps sticky overflow/carry status plus a saturating operation counter for the control path.

Parameters:
- WIDTH, 32, datapath width; must match the ALU.
- COUNT_WIDTH, 16, width of the op_count saturating counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU output bundle is valid this cycle.
- in_ready  out  1  stage can accept a bundle; registered (depends only on state, not on out_ready).
- in_result  in  WIDTH  ALU result.
- in_carryout  in  1  ALU carryout.
- in_overflow  in  1  ALU overflow.
- in_cmd  in  3  command used: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_result  out  WIDTH  head result.
- out_carry  out  1  qualified carry of head.
- out_overflow  out  1  qualified overflow of head.
- out_zero  out  1  head result == 0.
- out_cmd  out  3  head command.
- clear_status  in  1  synchronous clear of sticky flags and op_count.
- sticky_overflow  out  1  set by any accepted bundle with qualified overflow.
- sticky_carry  out  1  set by any accepted bundle with qualified carry.
- op_count  out  COUNT_WIDTH  number of accepted bundles, saturating.

Behaviour:
- Reset (rst_n low, async): FIFO empty, out_valid=0, in_ready=1, out_result=0, out_carry=0, out_overflow=0, out_zero=0, out_cmd=0, sticky_*=0, op_count=0. Reset asserted mid-transfer discards all buffered entries; nothing is emitted after release until a new push.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Storage is a 2-entry FIFO with a 1-bit write pointer, a 1-bit read pointer and a 2-bit occupancy count (0..2). Head data is driven from registers.
- in_ready = (count != 2), registered.
- Latency: a bundle pushed at edge N appears on out_* with out_valid=1 after edge N (first cycle it is visible). There is no combinational in-to-out path.
- Push and pop in the same cycle:
  - count=1: count stays 1, head advances to the new entry.
  - count=0: cannot occur, since out_valid=0.
  - count=2: no push is possible.
- Full (count=2) with a pop: in_ready rises on the next cycle only.
- Pointers wrap modulo 2.
- Data on out_* is held stable while out_valid && !out_ready. Out_* values with out_valid=0 are don't-care but must not be X after reset.
- Flag qualification at push:
  - Command 0, 1 or 3: carry=in_carryout, overflow=in_overflow.
  - Any other command: carry=0, overflow=0.
- zero is computed at push as (in_result == 0) over all WIDTH bits. The ALU zero output is not consumed.
- Status registers:
  - On each push, sticky_overflow |= qualified overflow and sticky_carry |= qualified carry.
  - On each push, op_count increments, saturating at 2^COUNT_WIDTH-1.
  - clear_status in the same cycle as a push: the push's contribution wins. Sticky flags become that push's qualified values; op_count becomes 1.
  - clear_status with no push: all status bits go to 0.

Test Plan:
- Reset, then push ADD bundle {result=32'h0000_0005, carry=0, ovf=0, cmd=0} with out_ready=1 -> one cycle later out_valid=1, out_result=5, out_zero=0; op_count=1.
- Push SUB bundle {result=32'h8000_0000, carry=0, ovf=1, cmd=1} -> out_overflow=1, sticky_overflow=1. Then push AND bundle {cmd=4, carry=1, ovf=1, result=0} -> out_carry=0, out_overflow=0, out_zero=1, sticky_carry stays 0.
- Hold out_ready=0 and push 3 bundles (results 1, 2, 3) -> in_ready falls after the 2nd push, the 3rd is held off, out_result stays 1. Raise out_ready -> outputs 1, 2, 3 in order with no loss or duplication.
- count=1 with simultaneous push(7) and pop(6) -> next cycle out_result=7, count=1, in_ready=1.
- Push with ovf=1 (cmd=3) in the same cycle as clear_status=1 -> sticky_overflow=1, op_count=1. Next cycle clear_status alone -> both sticky flags 0, op_count=0.
- Assert rst_n=0 asynchronously mid-cycle with 2 entries buffered -> out_valid drops immediately and in_ready=1. After release, no stale data is emitted.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and its consumer/control path.
// The slave modport is the result stage; the master modport is its environment.
interface alu_result_stage_if #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned COUNT_WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_result;
    logic                   in_carryout;
    logic                   in_overflow;
    logic [2:0]             in_cmd;

    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_result;
    logic                   out_carry;
    logic                   out_overflow;
    logic                   out_zero;
    logic [2:0]             out_cmd;

    logic                   clear_status;
    logic                   sticky_overflow;
    logic                   sticky_carry;
    logic [COUNT_WIDTH-1:0] op_count;

    modport master (
        output in_valid, in_result, in_carryout, in_overflow, in_cmd,
        output out_ready, clear_status,
        input  in_ready,
        input  out_valid, out_result, out_carry, out_overflow, out_zero, out_cmd,
        input  sticky_overflow, sticky_carry, op_count
    );

    modport slave (
        input  in_valid, in_result, in_carryout, in_overflow, in_cmd,
        input  out_ready, clear_status,
        output in_ready,
        output out_valid, out_result, out_carry, out_overflow, out_zero, out_cmd,
        output sticky_overflow, sticky_carry, op_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: 2-entry skid FIFO with per-command flag
// qualification, local zero detect, sticky carry/overflow and a saturating op counter.
module alu_result_stage #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    alu_result_stage_if.slave bus
);
    logic [WIDTH-1:0]       mem_result_q [2];
    logic [2:0]             mem_cmd_q    [2];
    logic [1:0]             mem_carry_q;
    logic [1:0]             mem_ovf_q;
    logic [1:0]             mem_zero_q;

    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             count_q, count_d;
    logic                   in_ready_q;

    logic                   sticky_ovf_q, sticky_ovf_d;
    logic                   sticky_carry_q, sticky_carry_d;
    logic [COUNT_WIDTH-1:0] op_count_q, op_count_d;

    logic                   push, pop;
    logic                   flags_valid;
    logic                   qual_carry, qual_ovf;
    logic                   in_zero;

    always_comb begin
        push        = bus.in_valid && in_ready_q;
        pop         = (count_q != 2'd0) && bus.out_ready;
        // Only arithmetic commands produce meaningful carry/overflow.
        flags_valid = (bus.in_cmd == 3'd0) || (bus.in_cmd == 3'd1) || (bus.in_cmd == 3'd3);
        qual_carry  = flags_valid && bus.in_carryout;
        qual_ovf    = flags_valid && bus.in_overflow;
        in_zero     = (bus.in_result == '0);
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_result_q[0] <= '0;
            mem_result_q[1] <= '0;
            mem_cmd_q[0]    <= '0;
            mem_cmd_q[1]    <= '0;
            mem_carry_q     <= '0;
            mem_ovf_q       <= '0;
            mem_zero_q      <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            in_ready_q      <= 1'b1;
        end else begin
            if (push) begin
                mem_result_q[wr_ptr_q] <= bus.in_result;
                mem_cmd_q[wr_ptr_q]    <= bus.in_cmd;
                mem_carry_q[wr_ptr_q]  <= qual_carry;
                mem_ovf_q[wr_ptr_q]    <= qual_ovf;
                mem_zero_q[wr_ptr_q]   <= in_zero;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            // Registered ready keeps out_ready off the upstream timing path.
            in_ready_q <= (count_d != 2'd2);
        end
    end

    always_comb begin
        if (bus.clear_status) begin
            // A push coinciding with clear still registers its own contribution.
            sticky_ovf_d   = push && qual_ovf;
            sticky_carry_d = push && qual_carry;
            op_count_d     = push ? COUNT_WIDTH'(1) : '0;
        end else begin
            sticky_ovf_d   = sticky_ovf_q   || (push && qual_ovf);
            sticky_carry_d = sticky_carry_q || (push && qual_carry);
            op_count_d     = op_count_q;
            if (push && !(&op_count_q)) begin
                op_count_d = op_count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
            op_count_q     <= '0;
        end else begin
            sticky_ovf_q   <= sticky_ovf_d;
            sticky_carry_q <= sticky_carry_d;
            op_count_q     <= op_count_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = (count_q != 2'd0);
    assign bus.out_result      = mem_result_q[rd_ptr_q];
    assign bus.out_carry       = mem_carry_q[rd_ptr_q];
    assign bus.out_overflow    = mem_ovf_q[rd_ptr_q];
    assign bus.out_zero        = mem_zero_q[rd_ptr_q];
    assign bus.out_cmd         = mem_cmd_q[rd_ptr_q];
    assign bus.sticky_overflow = sticky_ovf_q;
    assign bus.sticky_carry    = sticky_carry_q;
    assign bus.op_count        = op_count_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios followed by random traffic,
// compared against a queue-based model of the stage.
module tb_alu_result_stage;
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic         z;
        logic [2:0]   cmd;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_result_stage_if #(.WIDTH(W), .COUNT_WIDTH(CW)) bus ();

    alu_result_stage #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    entry_t      q[$];
    logic        m_sov;
    logic        m_sc;
    int unsigned m_cnt;
    int unsigned n_cmp;
    int unsigned n_fail;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"}, W'(bus.out_valid), W'(q.size() > 0));
        check({tag, ".in_ready"}, W'(bus.in_ready), W'(q.size() < 2));
        if (q.size() > 0) begin
            check({tag, ".out_result"}, bus.out_result, q[0].res);
            check({tag, ".out_carry"}, W'(bus.out_carry), W'(q[0].c));
            check({tag, ".out_overflow"}, W'(bus.out_overflow), W'(q[0].o));
            check({tag, ".out_zero"}, W'(bus.out_zero), W'(q[0].z));
            check({tag, ".out_cmd"}, W'(bus.out_cmd), W'(q[0].cmd));
        end
        check({tag, ".sticky_overflow"}, W'(bus.sticky_overflow), W'(m_sov));
        check({tag, ".sticky_carry"}, W'(bus.sticky_carry), W'(m_sc));
        check({tag, ".op_count"}, W'(bus.op_count), W'(m_cnt));
    endtask

    // One clock of stimulus; the model is updated from the handshake rules, then compared.
    task automatic cycle(input string tag, input logic v, input logic [W-1:0] r, input logic c,
                         input logic o, input logic [2:0] cmd, input logic rdy, input logic clr);
        entry_t e;
        entry_t drop;
        logic   push;
        logic   pop;
        logic   arith;
        bus.in_valid     = v;
        bus.in_result    = r;
        bus.in_carryout  = c;
        bus.in_overflow  = o;
        bus.in_cmd       = cmd;
        bus.out_ready    = rdy;
        bus.clear_status = clr;
        push  = v && (q.size() < 2);
        pop   = rdy && (q.size() > 0);
        arith = (cmd == 3'd0) || (cmd == 3'd1) || (cmd == 3'd3);
        e.res = r;
        e.c   = arith && c;
        e.o   = arith && o;
        e.z   = (r == 0);
        e.cmd = cmd;
        @(posedge clk);
        #1;
        if (pop) drop = q.pop_front();
        if (push) q.push_back(e);
        if (clr) begin
            m_sov = push && e.o;
            m_sc  = push && e.c;
            m_cnt = push ? 1 : 0;
        end else if (push) begin
            m_sov = m_sov || e.o;
            m_sc  = m_sc || e.c;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input logic rdy);
        cycle(tag, 1'b0, '0, 1'b0, 1'b0, 3'd0, rdy, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        m_sov = 1'b0;
        m_sc  = 1'b0;
        m_cnt = 0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        model_reset();
        bus.in_valid     = 1'b0;
        bus.in_result    = '0;
        bus.in_carryout  = 1'b0;
        bus.in_overflow  = 1'b0;
        bus.in_cmd       = 3'd0;
        bus.out_ready    = 1'b0;
        bus.clear_status = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_result", bus.out_result, '0);
        check("rst.out_carry", W'(bus.out_carry), '0);
        check("rst.out_overflow", W'(bus.out_overflow), '0);
        check("rst.out_zero", W'(bus.out_zero), '0);
        check("rst.out_cmd", W'(bus.out_cmd), '0);
        compare_all("rst");
        rst_n = 1'b1;
        idle("post_rst", 1'b1);

        // Basic push and flag qualification
        cycle("add5", 1'b1, 32'h0000_0005, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        cycle("sub_ovf", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
        cycle("and_zero", 1'b1, 32'h0000_0000, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
        idle("drain0", 1'b1);

        // Back-pressure: third push held off, then drained in order
        cycle("bp1", 1'b1, 32'd1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
        cycle("bp2", 1'b1, 32'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
        check("bp2.full", W'(bus.in_ready), '0);
        cycle("bp3_held", 1'b1, 32'd3, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
        check("bp3.head", bus.out_result, 32'd1);
        cycle("bp_pop1", 1'b1, 32'd3, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0);
        cycle("bp_push3", 1'b1, 32'd3, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0);
        idle("bp_drain", 1'b1);

        // Simultaneous push and pop at count=1
        cycle("pp6", 1'b1, 32'd6, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        cycle("pp7", 1'b1, 32'd7, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        check("pp7.head", bus.out_result, 32'd7);
        idle("pp_drain", 1'b1);

        // clear_status against a concurrent push, then alone
        cycle("clr_push", 1'b1, 32'd1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
        check("clr_push.cnt", W'(bus.op_count), 32'd1);
        cycle("clr_only", 1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Asynchronous reset with two entries buffered
        cycle("ar1", 1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle("ar2", 1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst.out_valid", W'(bus.out_valid), '0);
        check("arst.in_ready", W'(bus.in_ready), 32'd1);
        check("arst.out_result", bus.out_result, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) idle("arst_after", 1'b1);

        // Random traffic, including op_count saturation
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] r;
            logic [2:0]   cmd;
            r   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            cmd = 3'($urandom_range(0, 7));
            cycle("rand", 1'($urandom_range(0, 3) != 0), r, 1'($urandom), 1'($urandom), cmd,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
